// File: rtl/uart_xintf_bridge.sv
`timescale 1ns/1ps
// UART command-frame to XINTF bus bridge: parses 'w'/'r' frames, runs one timed bus cycle and
// answers over the UART TX handshake. Define XINTF_TIMEOUT_EN to bound the xready wait.
module uart_xintf_bridge #(
  parameter int unsigned DATA_BYTES  = 2,
  parameter int unsigned ADDR_BYTES  = 4,
  parameter int unsigned XA_W        = 16,
  parameter logic [8*ADDR_BYTES-XA_W-1:0] ZONE7_SEL = 16'h0020,
  parameter int unsigned LEAD_CYC    = 2,
  parameter int unsigned ACTIVE_CYC  = 5,
  parameter int unsigned TRAIL_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TX_GAP      = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic [XA_W-1:0]         xa,
  inout  wire  [8*DATA_BYTES-1:0] xd,
  output logic                    xwen,
  output logic                    xrdn,
  output logic                    zone_6_n,
  output logic                    zone_7_n,
  input  logic                    xready,
  output logic                    busy,
  output logic                    drop
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned AW = 8 * ADDR_BYTES;

  localparam logic [7:0]  ADDR_LAST  = 8'(ADDR_BYTES - 1);
  localparam logic [7:0]  DATA_LAST  = 8'(DATA_BYTES - 1);
  localparam logic [15:0] LEAD_LAST  = 16'(LEAD_CYC - 1);
  localparam logic [15:0] ACT_LAST   = 16'(ACTIVE_CYC - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(TRAIL_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(TX_GAP - 1);
`ifdef XINTF_TIMEOUT_EN
  localparam logic [15:0] TO_LAST    = 16'(ACTIVE_CYC + TIMEOUT_CYC - 1);
`endif

  localparam logic [1:0] P_IDLE = 2'd0, P_ADDR = 2'd1, P_DATA = 2'd2;
  localparam logic [2:0] B_IDLE = 3'd0, B_LEAD = 3'd1, B_ACT = 3'd2, B_TRAIL = 3'd3,
                         B_RESP = 3'd4;
  localparam logic [1:0] T_IDLE = 2'd0, T_WAIT = 2'd1, T_GAP = 2'd2;

  logic [1:0]    p_state;
  logic          p_write;
  logic [7:0]    p_idx;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [2:0]    b_state;
  logic [15:0]   b_cnt;
  logic          is_write;
  logic          timed_out;
  logic          xd_oe;
  logic [1:0]    t_state;
  logic [7:0]    t_idx;
  logic [15:0]   t_cnt;

  logic [AW-1:0] addr_ins;
  logic [AW-1:0] launch_addr;
  logic [DW-1:0] wdata_ins;
  logic          frame_done;
  logic          resp_done;
  logic [7:0]    t_last;
  logic [7:0]    resp_byte;

  assign xd = xd_oe ? wdata_q : {DW{1'bz}};

  always_comb begin
    addr_ins  = (addr_q & ~(AW'(8'hff) << {p_idx, 3'b000})) | (AW'(rx_data) << {p_idx, 3'b000});
    wdata_ins = (wdata_q & ~(DW'(8'hff) << {p_idx, 3'b000})) | (DW'(rx_data) << {p_idx, 3'b000});
    // A read frame completes on its last address byte, so that byte is not in addr_q yet.
    launch_addr = p_write ? addr_q : addr_ins;
    frame_done  = rx_valid && !busy &&
                  (((p_state == P_ADDR) && (p_idx == ADDR_LAST) && !p_write) ||
                   ((p_state == P_DATA) && (p_idx == DATA_LAST)));
    t_last      = (is_write || timed_out) ? 8'd0 : DATA_LAST;
    resp_done   = (b_state == B_RESP) && (t_state == T_GAP) && (t_cnt == GAP_LAST) &&
                  (t_idx == t_last);
    if (timed_out) begin
      resp_byte = 8'h21;
    end else if (is_write) begin
      resp_byte = 8'h6b;
    end else begin
      resp_byte = 8'(rdata_q >> {t_idx, 3'b000});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state <= P_IDLE;
      p_write <= 1'b0;
      p_idx   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= rx_valid && busy;
      if (frame_done) begin
        busy <= 1'b1;
      end else if (resp_done) begin
        busy <= 1'b0;
      end
      if (rx_valid && !busy) begin
        case (p_state)
          P_IDLE: begin
            p_idx <= 8'd0;
            if (rx_data == 8'h77 || rx_data == 8'h72) begin
              p_state <= P_ADDR;
              p_write <= (rx_data == 8'h77);
            end
          end
          P_ADDR: begin
            addr_q <= addr_ins;
            if (p_idx == ADDR_LAST) begin
              p_idx   <= 8'd0;
              p_state <= p_write ? P_DATA : P_IDLE;
            end else begin
              p_idx <= p_idx + 8'd1;
            end
          end
          P_DATA: begin
            wdata_q <= wdata_ins;
            if (p_idx == DATA_LAST) begin
              p_idx   <= 8'd0;
              p_state <= P_IDLE;
            end else begin
              p_idx <= p_idx + 8'd1;
            end
          end
          default: p_state <= P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_state   <= B_IDLE;
      b_cnt     <= 16'd0;
      is_write  <= 1'b0;
      timed_out <= 1'b0;
      xd_oe     <= 1'b0;
      rdata_q   <= '0;
      xa        <= '0;
      xwen      <= 1'b1;
      xrdn      <= 1'b1;
      zone_6_n  <= 1'b1;
      zone_7_n  <= 1'b1;
      t_state   <= T_IDLE;
      t_idx     <= 8'd0;
      t_cnt     <= 16'd0;
      tx_start  <= 1'b0;
      tx_data   <= 8'd0;
    end else begin
      tx_start <= 1'b0;
      case (b_state)
        B_IDLE: begin
          if (frame_done) begin
            b_state   <= B_LEAD;
            b_cnt     <= 16'd0;
            is_write  <= p_write;
            timed_out <= 1'b0;
            xa        <= launch_addr[XA_W-1:0];
            if (launch_addr[AW-1:XA_W] == ZONE7_SEL) begin
              zone_7_n <= 1'b0;
            end else begin
              zone_6_n <= 1'b0;
            end
          end
        end
        B_LEAD: begin
          if (b_cnt == LEAD_LAST) begin
            b_state <= B_ACT;
            b_cnt   <= 16'd0;
            if (is_write) begin
              xwen  <= 1'b0;
              xd_oe <= 1'b1;
            end else begin
              xrdn <= 1'b0;
            end
          end else begin
            b_cnt <= b_cnt + 16'd1;
          end
        end
        B_ACT: begin
          if ((b_cnt >= ACT_LAST) && xready) begin
            b_state <= B_TRAIL;
            b_cnt   <= 16'd0;
            xwen    <= 1'b1;
            xrdn    <= 1'b1;
            if (!is_write) begin
              rdata_q <= xd;
            end
`ifdef XINTF_TIMEOUT_EN
          end else if (b_cnt == TO_LAST) begin
            b_state   <= B_TRAIL;
            b_cnt     <= 16'd0;
            xwen      <= 1'b1;
            xrdn      <= 1'b1;
            timed_out <= 1'b1;
`endif
          end else if (b_cnt != 16'hffff) begin
            b_cnt <= b_cnt + 16'd1;
          end
        end
        B_TRAIL: begin
          // Write data is held one cycle past the strobe for hold time.
          xd_oe <= 1'b0;
          if (b_cnt == TRAIL_LAST) begin
            b_state  <= B_RESP;
            zone_6_n <= 1'b1;
            zone_7_n <= 1'b1;
            t_state  <= T_WAIT;
            t_idx    <= 8'd0;
          end else begin
            b_cnt <= b_cnt + 16'd1;
          end
        end
        B_RESP: begin
          case (t_state)
            T_WAIT: begin
              if (!tx_busy) begin
                tx_start <= 1'b1;
                tx_data  <= resp_byte;
                t_state  <= T_GAP;
                t_cnt    <= 16'd0;
              end
            end
            T_GAP: begin
              if (t_cnt == GAP_LAST) begin
                if (t_idx == t_last) begin
                  t_state <= T_IDLE;
                  b_state <= B_IDLE;
                end else begin
                  t_idx   <= t_idx + 8'd1;
                  t_state <= T_WAIT;
                end
              end else begin
                t_cnt <= t_cnt + 16'd1;
              end
            end
            default: t_state <= T_IDLE;
          endcase
        end
        default: b_state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xintf_bridge.sv
`timescale 1ns/1ps
// Bench for uart_xintf_bridge: random frames against a cycle-count/byte-list reference model,
// with emulated UART transmitter and XINTF device.
module tb_uart_xintf_bridge;

  localparam int ACT = 5, LEAD = 2, TRAIL = 2, TOC = 4, GAP = 10;
  localparam logic [15:0] Z7 = 16'h0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_busy, tx_start, xwen, xrdn, zone_6_n, zone_7_n, xready, busy, drop;
  logic [7:0]  tx_data;
  logic [15:0] xa;
  wire  [15:0] xd;
  logic        dev_oe;
  logic [15:0] dev_data;

  int          ready_low = 0;
  logic [15:0] rd_value = 16'h0;

  int checks = 0, failures = 0;
  int cyc = 0, z6_cnt = 0, z7_cnt = 0, both_cnt = 0, wen_cnt = 0, rdn_cnt = 0;
  int drop_cnt = 0, gv_cnt = 0;
  logic [15:0] xa_seen = 16'h0, xd_wr_seen = 16'h0, xd_after = 16'h0;
  logic [7:0]  tx_q[$];
  int          tx_cyc[$];

  assign xd = dev_oe ? dev_data : 16'hzzzz;

  uart_xintf_bridge #(
    .DATA_BYTES (2),
    .ADDR_BYTES (4),
    .XA_W       (16),
    .ZONE7_SEL  (Z7),
    .LEAD_CYC   (LEAD),
    .ACTIVE_CYC (ACT),
    .TRAIL_CYC  (TRAIL),
    .TIMEOUT_CYC(TOC),
    .TX_GAP     (GAP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .tx_busy (tx_busy),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .xa      (xa),
    .xd      (xd),
    .xwen    (xwen),
    .xrdn    (xrdn),
    .zone_6_n(zone_6_n),
    .zone_7_n(zone_7_n),
    .xready  (xready),
    .busy    (busy),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // UART transmitter model: busy for a random time after each start, plus spontaneous busy spells.
  initial begin : uart_tx_model
    int left;
    left = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (tx_start) begin
        tx_busy = 1'b1;
        left = $urandom_range(1, 25);
      end else if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        tx_busy = 1'b1;
        left = $urandom_range(1, 8);
      end
    end
  end

  // XINTF device: xready low for the first ready_low strobe cycles, junk data until ready.
  initial begin : xintf_dev
    int k;
    k = 0;
    xready = 1'b0;
    dev_oe = 1'b0;
    dev_data = 16'h0;
    forever begin
      @(posedge clk); #2;
      if (!xrdn || !xwen) k++; else k = 0;
      xready = (k > ready_low);
      dev_oe = !xrdn;
      dev_data = xready ? rd_value : 16'($urandom);
    end
  end

  initial begin : monitor
    logic prev_wen_low, last_busy;
    prev_wen_low = 1'b0;
    last_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!zone_6_n) z6_cnt++;
      if (!zone_7_n) z7_cnt++;
      if (!zone_6_n && !zone_7_n) both_cnt++;
      if (!xwen) wen_cnt++;
      if (!xrdn) rdn_cnt++;
      if (!xwen || !xrdn) xa_seen = xa;
      if (!xwen) xd_wr_seen = xd;
      if (prev_wen_low && xwen) xd_after = xd;
      prev_wen_low = !xwen;
      if (drop) drop_cnt++;
      if (tx_start) begin
        tx_q.push_back(tx_data);
        tx_cyc.push_back(cyc);
        if (last_busy) gv_cnt++;
      end
      last_busy = tx_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit wr, input logic [31:0] addr, input logic [15:0] data);
    send_byte(wr ? 8'h77 : 8'h72);
    for (int i = 0; i < 4; i++) send_byte(8'(addr >> (8 * i)));
    if (wr) for (int i = 0; i < 2; i++) send_byte(8'(data >> (8 * i)));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_xa"}, xa, 0);
    check({tag, "_xwen"}, xwen, 1);
    check({tag, "_xrdn"}, xrdn, 1);
    check({tag, "_zone6"}, zone_6_n, 1);
    check({tag, "_zone7"}, zone_7_n, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop"}, drop, 0);
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [15:0] data,
                        input int rl, input bit exp_to, input bit inject);
    int z6_0, z7_0, both_0, wen_0, rdn_0, drop_0, gv_0, q0, n, exp_act, exp_zone;
    logic [7:0] exp_bytes[$];
    logic [7:0] junk;
    bit z7;
    ready_low = rl;
    rd_value = data;
    z6_0 = z6_cnt; z7_0 = z7_cnt; both_0 = both_cnt; wen_0 = wen_cnt; rdn_0 = rdn_cnt;
    drop_0 = drop_cnt; gv_0 = gv_cnt; q0 = tx_q.size();
    repeat ($urandom_range(0, 2)) begin
      junk = 8'($urandom);
      if (junk == 8'h77 || junk == 8'h72) junk = 8'h00;
      send_byte(junk);
    end
    send_frame(wr, addr, data);
    check("busy_set", busy, 1);
    if (inject) send_byte(8'h72);
    n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_clear", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_act = exp_to ? ACT + TOC : ((rl + 1 > ACT) ? rl + 1 : ACT);
    exp_zone = LEAD + exp_act + TRAIL;
    z7 = (addr[31:16] == Z7);
    if (exp_to) exp_bytes.push_back(8'h21);
    else if (wr) exp_bytes.push_back(8'h6b);
    else begin
      exp_bytes.push_back(data[7:0]);
      exp_bytes.push_back(data[15:8]);
    end
    check("zone7_low", z7_cnt - z7_0, z7 ? exp_zone : 0);
    check("zone6_low", z6_cnt - z6_0, z7 ? 0 : exp_zone);
    check("zone_overlap", both_cnt - both_0, 0);
    check("xwen_low", wen_cnt - wen_0, wr ? exp_act : 0);
    check("xrdn_low", rdn_cnt - rdn_0, wr ? 0 : exp_act);
    check("xa", xa_seen, addr[15:0]);
    if (wr) begin
      check("xd_write", xd_wr_seen, data);
      check("xd_hold", xd_after, data);
    end
    check("tx_count", tx_q.size() - q0, exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && q0 + i < tx_q.size(); i++)
      check("tx_byte", tx_q[q0 + i], exp_bytes[i]);
    check("tx_gating", gv_cnt - gv_0, 0);
    check("drop_count", drop_cnt - drop_0, inject ? 1 : 0);
    if (!wr && !exp_to && tx_q.size() >= q0 + 2)
      check("tx_gap", (tx_cyc[q0 + 1] - tx_cyc[q0]) >= GAP, 1);
  endtask

  initial begin : main
    logic [31:0] addr;
    int q0, n;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    do_txn(1'b1, 32'h0010_1234, 16'hABCD, 0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h0020_5678, 16'hBEEF, 0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h0020_9abc, 16'h5AA5, 7, 1'b0, 1'b0);
    do_txn(1'b0, 32'h0033_0001, 16'h1357, 0, 1'b0, 1'b1);
    do_txn(1'b1, 32'hFFFF_FFFF, 16'h0000, 3, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[31:16] = Z7;
      else if (addr[31:16] == Z7) addr[31:16] = 16'h0021;
      do_txn(1'($urandom_range(0, 1)), addr, 16'($urandom), $urandom_range(0, 7), 1'b0,
             1'($urandom_range(0, 1)));
    end

`ifdef XINTF_TIMEOUT_EN
    do_txn(1'b0, 32'h0020_4444, 16'hDEAD, 1000, 1'b1, 1'b0);
    do_txn(1'b1, 32'h0005_0102, 16'h7788, 1000, 1'b1, 1'b0);
`endif

    // Reset in the middle of a stalled read strobe.
    ready_low = 1000;
    send_frame(1'b0, 32'h0020_0abc, 16'h0);
    n = 0;
    while (xrdn !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("strobe_before_reset", xrdn, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    q0 = tx_q.size();
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("no_tx_after_reset", tx_q.size() - q0, 0);
    check("zones_after_reset", {zone_6_n, zone_7_n}, 2'b11);
    do_txn(1'b0, 32'h0010_2468, 16'hC0DE, 2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_xintf_bridge.md
Name: uart_xintf_bridge

Overview:
Parametrised, fully synchronous UART-to-XINTF bus bridge.
- Parses 'w'/'r' command frames from a UART RX byte stream and runs one XINTF external-bus cycle per frame, with programmable lead/active/trail timing and xready wait extension.
- Returns read data, or a write acknowledge, through the UART TX handshake.
- Sits between uart_rx/uart_tx and the DSP external interface pins.

Parameters:
DATA_BYTES, 2, XINTF data width in bytes (xd width = 8*DATA_BYTES).
ADDR_BYTES, 4, address bytes per frame, LSB first.
XA_W, 16, width of xa; lower XA_W address bits go to xa.
ZONE7_SEL, 16'h0020, address bits above XA_W that select zone 7; any other value selects zone 6.
LEAD_CYC, 2, cycles from zone/xa assert to strobe assert (min 1).
ACTIVE_CYC, 5, minimum strobe-low cycles (min 1).
TRAIL_CYC, 2, cycles from strobe release to zone release (min 1).
TIMEOUT_CYC, 255, maximum extra strobe cycles waiting for xready.
TX_GAP, 10, cycles after a tx_start pulse before tx_busy is sampled again.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received UART byte
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle pulse: tx_data is valid to send
tx_data  out  8  byte to transmit
xa  out  XA_W  XINTF address
xd  inout  8*DATA_BYTES  XINTF data, driven only during write
xwen  out  1  write strobe, active low
xrdn  out  1  read strobe, active low
zone_6_n  out  1  zone 6 chip select, active low
zone_7_n  out  1  zone 7 chip select, active low
xready  in  1  external ready; strobe is extended while low
busy  out  1  high from frame complete until the response is fully sent
drop  out  1  one-cycle pulse when a byte is discarded

Behaviour:
- Reset: single clock domain. Reset value of every output: tx_start=0, tx_data=0, xa=0, xd=Z, xwen=1, xrdn=1, zone_6_n=1, zone_7_n=1, busy=0, drop=0. Parser, bus FSM and TX FSM all go to IDLE. Reset mid-cycle releases strobes and zones and tri-states xd at the next edge, with no response sent.
- Parser (advances only on clk edges with rx_valid=1):
  - P_IDLE: 0x77 'w' -> P_ADDR, write mode; 0x72 'r' -> P_ADDR, read mode; any other byte is ignored (no drop pulse).
  - P_ADDR: ADDR_BYTES bytes, LSB first. Then write -> P_DATA; read -> frame complete.
  - P_DATA: DATA_BYTES bytes, LSB first, then frame complete.
  - Frame complete sets busy=1 on the same edge and launches the bus FSM; the parser returns to P_IDLE.
  - While busy=1, every rx_valid byte is discarded and drop pulses for one cycle.
- Bus FSM: B_IDLE -> B_LEAD -> B_ACT -> B_TRAIL -> B_RESP.
  - Entering B_LEAD: xa = address[XA_W-1:0]; exactly one zone asserted, zone_7_n if address[8*ADDR_BYTES-1:XA_W]==ZONE7_SEL, else zone_6_n.
  - B_LEAD holds LEAD_CYC cycles.
  - Entering B_ACT: xwen=0 with xd driven with write data, or xrdn=0 with xd Z.
  - B_ACT lasts ACTIVE_CYC cycles, then extends while xready=0. Read data is latched from xd on the last B_ACT cycle, i.e. the first cycle at or after ACTIVE_CYC with xready=1.
  - Leaving B_ACT: strobes go high. For a write, xd stays driven one more cycle, then goes Z.
  - B_TRAIL holds TRAIL_CYC cycles, then zones go high and the FSM enters B_RESP, which hands the response to the TX FSM.
  - Total bus cycle with xready held high = LEAD_CYC+ACTIVE_CYC+TRAIL_CYC cycles.
- Response:
  - Read: DATA_BYTES bytes, LSB first.
  - Write: one byte, 0x6B 'k'.
  - Timeout: one byte, 0x21 '!' (see Optional Feature).
- TX FSM, per byte:
  - Wait for tx_busy=0, then drive tx_data and pulse tx_start for one cycle.
  - Wait TX_GAP cycles before sampling tx_busy for the next byte.
  - After the last byte's gap, busy drops to 0 and the bus FSM returns to B_IDLE.
- Arithmetic: wait and timeout counters saturate and never wrap. Address bits above XA_W are used only for zone decode.

Optional Feature:
XINTF_TIMEOUT_EN.
- Defined: if xready stays low for TIMEOUT_CYC cycles beyond ACTIVE_CYC, the strobe is forced high, read data is discarded, B_TRAIL runs normally, and the response is the single byte 0x21.
- Undefined: B_ACT waits on xready indefinitely, no timeout counter is built, and 0x21 is never sent.

Test Plan:
- Write, zone 6: rx 77,34,12,10,00,CD,AB with xready=1 -> zone_6_n low, xa=0x1234, xwen low 5 cycles with xd=0xABCD; tx one byte 0x6B; total bus cycle 9 clocks.
- Read, zone 7: rx 72,78,56,20,00, device drives xd=0xBEEF, xready=1 -> zone_7_n low, xrdn low; tx EF then BE, each tx_start gated on tx_busy=0.
- Ready extension: read with xready low 7 cycles after strobe assert -> xrdn low exactly 8 cycles; data latched on the xready=1 cycle.
- Timeout (XINTF_TIMEOUT_EN, TIMEOUT_CYC=4): xready held 0 -> xrdn released after 9 cycles; tx 0x21 only.
- Busy drop and reset: send an extra 'r' while busy=1 -> drop pulses once and the parser stays in P_IDLE. Assert reset mid-B_ACT -> next edge all outputs at reset values and xd=Z; no tx_start follows.
